lcd_host: RTL and testbench
===========================

LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 32: number of command-script entries (power of two).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096: watchdog limit in clock cycles.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-004 SHALL have ports: cmd out 4, command code; cmd_valid out 1, command strobe; busy in 1, engine busy; done in 1, engine finished.
REQ-005 SHALL have ports: IROM_rd in 1, read request; IROM_A in 6, read address; IROM_Q out 8, read data.
REQ-006 SHALL have ports: IRAM_valid in 1, write strobe; IRAM_A in 6, write address; IRAM_D in 8, write data.
REQ-007 SHALL have ports: rom_we in 1; rom_addr in 6; rom_data in 8: image preload.
REQ-008 SHALL have ports: prog_we in 1; prog_addr in log2(CMD_DEPTH); prog_cmd in 4: script load.
REQ-009 SHALL have ports: start in 1; ram_rd_addr in 6; ram_rd_data out 8; finished out 1; error out 1.

Function
REQ-010 SHALL hold a 64x8 image ROM; rom_we writes rom_data at rom_addr on the clock edge.
REQ-011 SHALL return IROM_Q = rom[IROM_A] one cycle after IROM_rd is sampled high; IROM_Q holds its value while IROM_rd is low.
REQ-012 SHALL use read-before-write: rom_we and IROM_rd to the same address in one cycle return the old byte.
REQ-013 SHALL write IRAM_D into a 64x8 capture RAM at IRAM_A on every edge with IRAM_valid=1, in any state.
REQ-014 SHALL register ram_rd_data = ram[ram_rd_addr] with one-cycle latency; a same-cycle IRAM write returns the old byte.
REQ-015 SHALL accept prog_we only in IDLE; prog_we in any other state is ignored.
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT_HI -> WAIT_LO -> (ISSUE | WAIT_DONE) -> FINISH.
REQ-017 SHALL leave IDLE on start=1, set script pointer to 0 and clear finished/error; start outside IDLE is ignored.
REQ-018 SHALL, in ISSUE, wait until busy=0, then drive cmd=script[ptr] with cmd_valid=1 for exactly one cycle.
REQ-019 SHALL, in WAIT_HI, wait for busy=1; in WAIT_LO, wait for busy=0, then increment ptr and return to ISSUE.
REQ-020 SHALL treat cmd=0 (write) as terminal: after issuing it, go directly to WAIT_DONE.
REQ-021 SHALL, when ptr wraps past CMD_DEPTH-1 with no write command issued, issue an implied cmd=0 as the terminal command.
REQ-022 SHALL go from WAIT_DONE to FINISH on done=1, set finished=1, and return to IDLE on the next cycle with finished held high until the next start.
REQ-023 SHALL drive cmd=0 and cmd_valid=0 whenever no command is being strobed.

Reset
REQ-024 SHALL, on reset, enter IDLE with cmd=0, cmd_valid=0, IROM_Q=0, ram_rd_data=0, finished=0, error=0 and ptr=0.
REQ-025 SHALL, on reset mid-run, abort on the next edge without issuing a further strobe; ROM, RAM and script contents are not reset.

Configuration
REQ-026 SHALL implement watchdog logic only when LCD_HOST_TIMEOUT_EN is defined.
REQ-027 SHALL, with the watchdog enabled, count cycles in WAIT_HI, WAIT_LO and WAIT_DONE, clear the count on every state change, and at TIMEOUT_CYC set error=1, set finished=1 and go to IDLE.
REQ-028 SHALL, without the watchdog, tie error to 0 and wait in those states indefinitely.

Structure
REQ-029 SHALL take command codes 0..11 (WRITE, SHIFT_UP/DOWN/LEFT/RIGHT, MAX, MIN, AVG, CCW, CW, MIRROR_X, MIRROR_Y) and the FSM state enum from shared package lcd_pkg.
REQ-030 SHALL place the 64x8 read-before-write memory in one sub-module, lcd_mem_64x8, instantiated twice (ROM and capture RAM).

Verification
REQ-031 SHALL verify: preload rom[5]=8'hA7, pulse IROM_rd with IROM_A=5 -> IROM_Q=8'hA7 on the next cycle.
REQ-032 SHALL verify: script {1,5,0}, responder raises busy for 3 cycles per command -> exactly three one-cycle strobes with cmd 1, 5, 0, never while busy=1.
REQ-033 SHALL verify: IRAM_valid writes 8'h3C at address 63, then done=1 -> ram_rd_data=8'h3C one cycle after ram_rd_addr=63, and finished=1.
REQ-034 SHALL verify: script of 32 non-zero entries -> 33rd strobe carries cmd=0.
REQ-035 SHALL verify: with LCD_HOST_TIMEOUT_EN defined and busy stuck at 0 after a strobe -> error=1 and finished=1 after 4096 cycles.
REQ-036 SHALL verify: reset asserted in WAIT_LO -> next cycle cmd_valid=0, state IDLE, and a subsequent start replays the script from entry 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD host controller slice.
//   - MEM_AW / MEM_DW : geometry of the 64x8 image ROM and capture RAM
//   - CMD_W           : width of an engine command code
//   - cmd_e           : engine command codes 0..11 (WRITE is the terminal one)
//   - state_e         : host sequencer states
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam int MEM_AW = 6;
    localparam int MEM_DW = 8;
    localparam int CMD_W  = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_WRITE       = 4'd0,
        CMD_SHIFT_UP    = 4'd1,
        CMD_SHIFT_DOWN  = 4'd2,
        CMD_SHIFT_LEFT  = 4'd3,
        CMD_SHIFT_RIGHT = 4'd4,
        CMD_MAX         = 4'd5,
        CMD_MIN         = 4'd6,
        CMD_AVG         = 4'd7,
        CMD_CCW         = 4'd8,
        CMD_CW          = 4'd9,
        CMD_MIRROR_X    = 4'd10,
        CMD_MIRROR_Y    = 4'd11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        WAIT_DONE,
        FINISH
    } state_e;

endpackage

// File: rtl/lcd_mem_64x8.sv
// ---------------------------------------------------------------------------
// lcd_mem_64x8
// 64 x 8 memory with one write port and one registered read port.
// A read and a write to the same address in the same cycle return the byte
// that was stored before the write. The array itself is never reset; only the
// read register clears on reset.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (read register)
//   we, waddr, wdata  : write port, written on the rising edge when we=1
//   re, raddr         : read request; rdata updates only when re=1
//   rdata             : registered read data, holds while re=0
// ---------------------------------------------------------------------------
module lcd_mem_64x8
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [MEM_DW-1:0] wdata,
    input  logic              re,
    input  logic [MEM_AW-1:0] raddr,
    output logic [MEM_DW-1:0] rdata
);

    logic [MEM_DW-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array gives read-before-write for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lcd_host.sv
// ---------------------------------------------------------------------------
// lcd_host
// Host-side sequencer for an LCD image engine. It holds an image ROM the
// engine reads, a capture RAM the engine writes, and a command script that is
// replayed to the engine one strobe at a time with a busy handshake.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   cmd, cmd_valid               : command code and one-cycle strobe
//   busy, done                   : engine handshake inputs
//   IROM_rd, IROM_A, IROM_Q      : engine read port into the image ROM
//   IRAM_valid, IRAM_A, IRAM_D   : engine write port into the capture RAM
//   rom_we, rom_addr, rom_data   : image preload into the ROM
//   prog_we, prog_addr, prog_cmd : script load (honoured only while idle)
//   start                        : begin replaying the script
//   ram_rd_addr, ram_rd_data     : host readback of the capture RAM
//   finished, error              : run complete / watchdog expired
// Build option: define LCD_HOST_TIMEOUT_EN to enable the wait-state watchdog;
// otherwise error is tied low and waits are unbounded.
// ---------------------------------------------------------------------------
module lcd_host
    import lcd_pkg::*;
#(
    parameter int CMD_DEPTH   = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [CMD_W-1:0]             cmd,
    output logic                         cmd_valid,
    input  logic                         busy,
    input  logic                         done,
    input  logic                         IROM_rd,
    input  logic [MEM_AW-1:0]            IROM_A,
    output logic [MEM_DW-1:0]            IROM_Q,
    input  logic                         IRAM_valid,
    input  logic [MEM_AW-1:0]            IRAM_A,
    input  logic [MEM_DW-1:0]            IRAM_D,
    input  logic                         rom_we,
    input  logic [MEM_AW-1:0]            rom_addr,
    input  logic [MEM_DW-1:0]            rom_data,
    input  logic                         prog_we,
    input  logic [$clog2(CMD_DEPTH)-1:0] prog_addr,
    input  logic [CMD_W-1:0]             prog_cmd,
    input  logic                         start,
    input  logic [MEM_AW-1:0]            ram_rd_addr,
    output logic [MEM_DW-1:0]            ram_rd_data,
    output logic                         finished,
    output logic                         error
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CMD_DEPTH - 1);

    state_e           state;
    logic [PTR_W-1:0] ptr;
    logic             wrapped;
    logic [CMD_W-1:0] script [CMD_DEPTH];

    lcd_mem_64x8 u_rom (
        .clk   (clk),
        .reset (reset),
        .we    (rom_we),
        .waddr (rom_addr),
        .wdata (rom_data),
        .re    (IROM_rd),
        .raddr (IROM_A),
        .rdata (IROM_Q)
    );

    lcd_mem_64x8 u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (IRAM_valid),
        .waddr (IRAM_A),
        .wdata (IRAM_D),
        .re    (1'b1),
        .raddr (ram_rd_addr),
        .rdata (ram_rd_data)
    );

    // Script storage is only writable while idle so a running replay can
    // never see its commands change underneath it.
    always_ff @(posedge clk) begin
        if (prog_we && state == IDLE) begin
            script[prog_addr] <= prog_cmd;
        end
    end

`ifdef LCD_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;
    logic            wait_exit;

    // A wait state is being left this cycle exactly when its handshake
    // condition is met; the watchdog restarts on that transition.
    always_comb begin
        in_wait   = (state == WAIT_HI) || (state == WAIT_LO) || (state == WAIT_DONE);
        wait_exit = ((state == WAIT_HI) && busy)
                 || ((state == WAIT_LO) && !busy)
                 || ((state == WAIT_DONE) && done);
    end
`else
    assign error = 1'b0;
`endif

    // Sequencer. cmd/cmd_valid default to zero every cycle so a strobe is
    // only ever one cycle wide. Once the pointer has wrapped without a WRITE
    // being seen, the next issue slot sends an implied WRITE to close the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            ptr       <= '0;
            wrapped   <= 1'b0;
            finished  <= 1'b0;
`ifdef LCD_HOST_TIMEOUT_EN
            error     <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            cmd       <= '0;
            cmd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= '0;
                        wrapped  <= 1'b0;
                        finished <= 1'b0;
`ifdef LCD_HOST_TIMEOUT_EN
                        error    <= 1'b0;
`endif
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!busy) begin
                        cmd_valid <= 1'b1;
                        if (wrapped) begin
                            cmd   <= CMD_WRITE;
                            state <= WAIT_DONE;
                        end else begin
                            cmd   <= script[ptr];
                            state <= (script[ptr] == CMD_WRITE) ? WAIT_DONE : WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!busy) begin
                        ptr <= ptr + PTR_W'(1);
                        if (ptr == LAST_PTR) begin
                            wrapped <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        finished <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef LCD_HOST_TIMEOUT_EN
            // Placed after the case so an expiry overrides the normal
            // next-state and flags the run as finished with an error.
            if (in_wait && !wait_exit) begin
                if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    wd_cnt   <= '0;
                    error    <= 1'b1;
                    finished <= 1'b1;
                    state    <= IDLE;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lcd_host.sv
// ---------------------------------------------------------------------------
// tb_lcd_host
// Self-checking bench for lcd_host. A strobe model turns the bench's copy of
// the script into the list of commands the engine must receive; one process
// compares every strobe against that list while acting as the engine
// responder. Directed steps cover ROM/RAM access, reset, script replay,
// wrap-around and the watchdog (LCD_HOST_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_lcd_host;
    import lcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       rom_we;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [3:0] prog_cmd;
    logic       start;
    logic [5:0] ram_rd_addr;
    logic [7:0] ram_rd_data;
    logic       finished;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] script_model [32];
    logic [3:0] exp_q [$];
    int         strobes  = 0;
    logic [3:0] last_cmd = 4'hF;

    logic resp_auto  = 1'b1;
    logic busy_force = 1'b0;
    logic done_force = 1'b0;

    lcd_host #(.CMD_DEPTH(32), .TIMEOUT_CYC(4096)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .busy        (busy),
        .done        (done),
        .IROM_rd     (IROM_rd),
        .IROM_A      (IROM_A),
        .IROM_Q      (IROM_Q),
        .IRAM_valid  (IRAM_valid),
        .IRAM_A      (IRAM_A),
        .IRAM_D      (IRAM_D),
        .rom_we      (rom_we),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_cmd    (prog_cmd),
        .start       (start),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .finished    (finished),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // The engine must see every script entry up to and including the first
    // WRITE; a script with no WRITE is followed by one implied WRITE.
    function automatic void buildExpected();
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(script_model[i]);
            if (script_model[i] == 4'd0) return;
        end
        exp_q.push_back(4'd0);
    endfunction

    task automatic progWrite(input int addr, input logic [3:0] val);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 5'(addr);
        prog_cmd  = val;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic loadScript(input int addr, input logic [3:0] val);
        progWrite(addr, val);
        script_model[addr] = val;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitStrobe(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd_valid !== 1'b1 && n < budget);
        if (cmd_valid !== 1'b1) checkOutput(name, 32'(cmd_valid), 32'd1);
    endtask

    task automatic waitFinished(input int budget, input string name);
        int n;
        n = 0;
        while (finished !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(finished), 32'd1);
    endtask

    // Strobe checker and engine responder in one process, so the busy level
    // checked against a strobe is the one the DUT sampled when it launched it.
    initial begin
        int bcnt;
        int dcnt;
        bcnt = 0;
        dcnt = 0;
        busy = 1'b0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                strobes++;
                last_cmd = cmd;
                checkOutput("strobe_busy_low", 32'(busy), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_strobe: got cmd %0d, required no strobe", cmd);
                end else begin
                    checkOutput("strobe_cmd", 32'(cmd), 32'(exp_q.pop_front()));
                end
            end else begin
                checkOutput("cmd_zero_when_idle", 32'(cmd), 32'd0);
            end

            if (resp_auto) begin
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) busy = 1'b0;
                end
                done = 1'b0;
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) done = 1'b1;
                end
                if (cmd_valid === 1'b1) begin
                    busy = 1'b1;
                    bcnt = 3;
                    if (cmd == 4'd0) dcnt = 4;
                end
            end else begin
                busy = busy_force;
                done = done_force;
                bcnt = 0;
                dcnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int wd;
        reset = 1'b1;
        IROM_rd = 1'b0; IROM_A = '0; IRAM_valid = 1'b0; IRAM_A = '0; IRAM_D = '0;
        rom_we = 1'b0; rom_addr = '0; rom_data = '0; prog_we = 1'b0; prog_addr = '0;
        prog_cmd = '0; start = 1'b0; ram_rd_addr = '0;
        for (int i = 0; i < 32; i++) script_model[i] = 4'hF;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd", 32'(cmd), 32'd0);
        checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_irom_q", 32'(IROM_Q), 32'd0);
        checkOutput("rst_ram_rd_data", 32'(ram_rd_data), 32'd0);
        checkOutput("rst_finished", 32'(finished), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;

        // Image ROM: preload, read, hold, read-before-write
        @(negedge clk); rom_we = 1'b1; rom_addr = 6'd5; rom_data = 8'hA7;
        @(negedge clk); rom_addr = 6'd6; rom_data = 8'h5B;
        @(negedge clk); rom_we = 1'b0; IROM_rd = 1'b1; IROM_A = 6'd5;
        @(negedge clk); IROM_rd = 1'b0; IROM_A = 6'd6;
        checkOutput("rom_read_5", 32'(IROM_Q), 32'hA7);
        @(negedge clk);
        checkOutput("rom_hold", 32'(IROM_Q), 32'hA7);
        rom_we = 1'b1; rom_addr = 6'd6; rom_data = 8'hC4; IROM_rd = 1'b1; IROM_A = 6'd6;
        @(negedge clk); rom_we = 1'b0;
        checkOutput("rom_rbw_old", 32'(IROM_Q), 32'h5B);
        @(negedge clk); IROM_rd = 1'b0;
        checkOutput("rom_rbw_new", 32'(IROM_Q), 32'hC4);

        // Capture RAM: read-before-write on the readback port
        @(negedge clk); IRAM_valid = 1'b1; IRAM_A = 6'd10; IRAM_D = 8'h55; ram_rd_addr = 6'd10;
        @(negedge clk); IRAM_D = 8'h66;
        @(negedge clk); IRAM_valid = 1'b0;
        checkOutput("ram_rbw_old", 32'(ram_rd_data), 32'h55);
        @(negedge clk);
        checkOutput("ram_rbw_new", 32'(ram_rd_data), 32'h66);

        // Script {1,5,0}: mid-run IRAM write, ignored prog_we and start
        loadScript(0, 4'd1);
        loadScript(1, 4'd5);
        loadScript(2, 4'd0);
        buildExpected();
        strobes = 0;
        applyStimulus();
        waitStrobe(50, "run1_first_strobe");
        @(negedge clk);
        IRAM_valid = 1'b1; IRAM_A = 6'd63; IRAM_D = 8'h3C;
        prog_we = 1'b1; prog_addr = 5'd1; prog_cmd = 4'd9;
        start = 1'b1;
        @(negedge clk);
        IRAM_valid = 1'b0; prog_we = 1'b0; start = 1'b0;
        waitFinished(300, "run1_finished");
        checkOutput("run1_strobes", 32'(strobes), 32'd3);
        checkOutput("run1_last_cmd", 32'(last_cmd), 32'd0);
        checkOutput("run1_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk); ram_rd_addr = 6'd63;
        @(negedge clk);
        checkOutput("ram_read_63", 32'(ram_rd_data), 32'h3C);
        repeat (3) @(negedge clk);
        checkOutput("finished_held", 32'(finished), 32'd1);
        checkOutput("idle_after_finish", 32'(dut.state), 32'(IDLE));

        // Replay: script unchanged by the mid-run prog_we, finished cleared by start
        buildExpected();
        strobes = 0;
        applyStimulus();
        checkOutput("start_clears_finished", 32'(finished), 32'd0);
        waitFinished(300, "run2_finished");
        checkOutput("run2_strobes", 32'(strobes), 32'd3);

        // 32 non-zero entries: a 33rd, implied WRITE strobe
        for (int i = 0; i < 32; i++) loadScript(i, 4'((i % 11) + 1));
        buildExpected();
        strobes = 0;
        applyStimulus();
        waitFinished(2000, "wrap_finished");
        checkOutput("wrap_strobes", 32'(strobes), 32'd33);
        checkOutput("wrap_last_cmd", 32'(last_cmd), 32'd0);

        // Reset while in WAIT_LO, then replay from entry 0
        loadScript(0, 4'd2);
        loadScript(1, 4'd3);
        loadScript(2, 4'd4);
        loadScript(3, 4'd0);
        buildExpected();
        applyStimulus();
        waitStrobe(50, "abort_first_strobe");
        @(negedge clk);
        checkOutput("abort_in_wait_lo", 32'(dut.state), 32'(WAIT_LO));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("abort_state", 32'(dut.state), 32'(IDLE));
        checkOutput("abort_finished", 32'(finished), 32'd0);
        reset = 1'b0;
        buildExpected();
        strobes = 0;
        applyStimulus();
        waitFinished(300, "replay_finished");
        checkOutput("replay_strobes", 32'(strobes), 32'd4);
        checkOutput("replay_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk); IROM_rd = 1'b1; IROM_A = 6'd5;
        @(negedge clk); IROM_rd = 1'b0;
        checkOutput("rom_kept_over_reset", 32'(IROM_Q), 32'hA7);

        // busy stuck low after a strobe
        loadScript(0, 4'd7);
        loadScript(1, 4'd0);
        buildExpected();
        resp_auto = 1'b0;
        busy_force = 1'b0;
        done_force = 1'b0;
        applyStimulus();
        waitStrobe(50, "stuck_first_strobe");
        wd = 0;
`ifdef LCD_HOST_TIMEOUT_EN
        while (error !== 1'b1 && wd < 5000) begin
            @(negedge clk);
            wd++;
        end
        checkOutput("wd_cycles", 32'(wd), 32'd4096);
        checkOutput("wd_error", 32'(error), 32'd1);
        checkOutput("wd_finished", 32'(finished), 32'd1);
        checkOutput("wd_state", 32'(dut.state), 32'(IDLE));
`else
        repeat (5000) @(negedge clk);
        checkOutput("nowd_error", 32'(error), 32'd0);
        checkOutput("nowd_finished", 32'(finished), 32'd0);
        checkOutput("nowd_still_waiting", 32'(dut.state), 32'(WAIT_HI));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        exp_q.delete();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
